// File: rtl/super_pkg.sv
// ============================================================================
// Module   : super_pkg
// Purpose  : Shared decoded-instruction and operand types for the issue stage,
//            plus the ALU issue arbiter state record.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package super_pkg;

   localparam int unsigned STARVE_W = 4;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [3:0]  cheri_op;
      logic        is_jal;
      logic [31:0] imm;
   } ir_dec_t;

   typedef struct packed {
      logic [31:0] rs1;
      logic [31:0] rs2;
   } full_data2_t;

   typedef struct packed {
      logic                valid;
      logic                src;
      logic [STARVE_W-1:0] starve;
   } arb_state_t;

   // Builds without capability support must never present CHERI/JAL fields downstream.
   function automatic ir_dec_t strip_cheri(input ir_dec_t instr);
      ir_dec_t r;
      r          = instr;
      r.cheri_op = '0;
      r.is_jal   = 1'b0;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_arb_prio.sv
// ============================================================================
// Module   : alu_arb_prio
// Purpose  : Combinational two-slot priority select: the older slot 0 wins
//            unless slot 1 has been starved for STARVE_LIMIT lost cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arb_prio
   import super_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                i_req0_valid,
   input  logic                i_req1_valid,
   input  logic [STARVE_W-1:0] i_starve_q,
   output logic                o_grant0,
   output logic                o_grant1
);

   localparam logic [STARVE_W-1:0] c_starve_limit = STARVE_W'(STARVE_LIMIT);

   logic w_force1;

   assign w_force1 = i_req1_valid & (i_starve_q == c_starve_limit);
   assign o_grant1 = i_req1_valid & (~i_req0_valid | w_force1);
   assign o_grant0 = i_req0_valid & ~o_grant1;

endmodule

`default_nettype wire

// File: rtl/alu_issue_arb.sv
// ============================================================================
// Module   : alu_issue_arb
// Purpose  : Two-slot issue arbiter feeding the ALU pipeline through a single
//            output register, with starvation protection for slot 1.
//            Optional: define ALU_ISSUE_ARB_PERF_EN to add perf_conflict_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_arb
   import super_pkg::*;
#(
   parameter int unsigned StarveLimit = 4,
   parameter bit          CHERIoTEn   = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic        req0_valid_i,
   input  logic        req1_valid_i,
   output logic        req0_rdy_o,
   output logic        req1_rdy_o,
   input  ir_dec_t     req0_instr_i,
   input  ir_dec_t     req1_instr_i,
   input  full_data2_t req0_data_i,
   input  full_data2_t req1_data_i,
   input  logic        alupl_rdy_i,
   output logic        us_valid_o,
   output ir_dec_t     instr_o,
   output full_data2_t full_data2_o,
`ifdef ALU_ISSUE_ARB_PERF_EN
   output logic [31:0] perf_conflict_o,
`endif
   output logic        grant_src_o
);

   localparam logic [STARVE_W-1:0] c_starve_limit = STARVE_W'(StarveLimit);

   arb_state_t          r_state;
   ir_dec_t             r_instr;
   full_data2_t         r_data;

   logic                w_load_en;
   logic                w_accept;
   logic                w_grant0;
   logic                w_grant1;
   logic                w_grant_any;
   ir_dec_t             w_mux_instr;
   ir_dec_t             w_sel_instr;
   full_data2_t         w_sel_data;
   logic [STARVE_W-1:0] w_starve_d;

   alu_arb_prio #(
      .STARVE_LIMIT (StarveLimit)
   ) u_prio (
      .i_req0_valid (req0_valid_i),
      .i_req1_valid (req1_valid_i),
      .i_starve_q   (r_state.starve),
      .o_grant0     (w_grant0),
      .o_grant1     (w_grant1)
   );

   assign w_load_en   = ~r_state.valid | alupl_rdy_i;
   assign w_accept    = w_load_en & ~flush_i;
   assign w_grant_any = w_grant0 | w_grant1;

   assign req0_rdy_o  = w_accept & w_grant0;
   assign req1_rdy_o  = w_accept & w_grant1;

   assign w_mux_instr = w_grant1 ? req1_instr_i : req0_instr_i;
   assign w_sel_data  = w_grant1 ? req1_data_i  : req0_data_i;

   generate
      if (CHERIoTEn) begin : g_cheri_en
         assign w_sel_instr = w_mux_instr;
      end else begin : g_cheri_dis
         assign w_sel_instr = strip_cheri(w_mux_instr);
      end
   endgenerate

   // Starvation only accrues on cycles where slot 1 actually lost an accept.
   always_comb begin
      w_starve_d = r_state.starve;
      if (!req1_valid_i || (w_accept && w_grant1)) begin
         w_starve_d = '0;
      end else if (w_accept && w_grant0 && (r_state.starve != c_starve_limit)) begin
         w_starve_d = r_state.starve + STARVE_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= '0;
         r_instr <= '0;
         r_data  <= '0;
      end else if (flush_i) begin
         r_state.valid  <= 1'b0;
         r_state.starve <= '0;
      end else begin
         if (w_load_en) begin
            r_state.valid <= w_grant_any;
            if (w_grant_any) begin
               r_state.src <= w_grant1;
               r_instr     <= w_sel_instr;
               r_data      <= w_sel_data;
            end
         end
         r_state.starve <= w_starve_d;
      end
   end

   assign us_valid_o   = r_state.valid;
   assign grant_src_o  = r_state.src;
   assign instr_o      = r_instr;
   assign full_data2_o = r_data;

`ifdef ALU_ISSUE_ARB_PERF_EN
   logic [31:0] r_perf_conflict;

   // Counts contention whenever the register could load; flush does not reset it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_perf_conflict <= '0;
      end else if (req0_valid_i && req1_valid_i && w_load_en) begin
         r_perf_conflict <= r_perf_conflict + 32'd1;
      end
   end

   assign perf_conflict_o = r_perf_conflict;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_arb.sv
// ============================================================================
// Module   : tb_alu_issue_arb
// Purpose  : Directed self-checking bench for alu_issue_arb.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_arb;
   import super_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        flush_i;
   logic        req0_valid_i;
   logic        req1_valid_i;
   logic        req0_rdy_o;
   logic        req1_rdy_o;
   ir_dec_t     req0_instr_i;
   ir_dec_t     req1_instr_i;
   full_data2_t req0_data_i;
   full_data2_t req1_data_i;
   logic        alupl_rdy_i;
   logic        us_valid_o;
   ir_dec_t     instr_o;
   full_data2_t full_data2_o;
   logic        grant_src_o;
`ifdef ALU_ISSUE_ARB_PERF_EN
   logic [31:0] perf_conflict_o;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   alu_issue_arb #(
      .StarveLimit (4),
      .CHERIoTEn   (1'b1)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .flush_i         (flush_i),
      .req0_valid_i    (req0_valid_i),
      .req1_valid_i    (req1_valid_i),
      .req0_rdy_o      (req0_rdy_o),
      .req1_rdy_o      (req1_rdy_o),
      .req0_instr_i    (req0_instr_i),
      .req1_instr_i    (req1_instr_i),
      .req0_data_i     (req0_data_i),
      .req1_data_i     (req1_data_i),
      .alupl_rdy_i     (alupl_rdy_i),
      .us_valid_o      (us_valid_o),
      .instr_o         (instr_o),
      .full_data2_o    (full_data2_o),
`ifdef ALU_ISSUE_ARB_PERF_EN
      .perf_conflict_o (perf_conflict_o),
`endif
      .grant_src_o     (grant_src_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic ir_dec_t mk_instr(input int t);
      ir_dec_t i;
      i.opcode   = 7'h33;
      i.rd       = 5'(t);
      i.rs1      = 5'(t + 1);
      i.rs2      = 5'(t + 2);
      i.cheri_op = 4'(t) | 4'h8;
      i.is_jal   = t[0];
      i.imm      = 32'(t) + 32'h1000;
      return i;
   endfunction

   function automatic full_data2_t mk_data(input int t);
      full_data2_t d;
      d.rs1 = 32'(t * 3);
      d.rs2 = 32'(t + 1000);
      return d;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic set_in(input logic v0, input logic v1, input logic ardy, input logic fl,
                         input int t0, input int t1);
      req0_valid_i = v0;
      req1_valid_i = v1;
      alupl_rdy_i  = ardy;
      flush_i      = fl;
      req0_instr_i = mk_instr(t0);
      req1_instr_i = mk_instr(t1);
      req0_data_i  = mk_data(t0);
      req1_data_i  = mk_data(t1);
      #1;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Both slots valid, pipeline ready; exp1 says whether slot 1 must win.
   task automatic arb_cycle(input string tag, input bit exp1, input int t0, input int t1);
      set_in(1'b1, 1'b1, 1'b1, 1'b0, t0, t1);
      check_eq({tag, ".rdy0"}, 64'(req0_rdy_o), 64'(!exp1));
      check_eq({tag, ".rdy1"}, 64'(req1_rdy_o), 64'(exp1));
      tick();
      check_eq({tag, ".valid"}, 64'(us_valid_o), 64'd1);
      check_eq({tag, ".src"}, 64'(grant_src_o), 64'(exp1));
      check_eq({tag, ".instr"}, 64'(instr_o), 64'(mk_instr(exp1 ? t1 : t0)));
      check_eq({tag, ".data"}, 64'(full_data2_o), 64'(mk_data(exp1 ? t1 : t0)));
   endtask

   initial begin
      rst_ni = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      #10;
      check_eq("rst.valid", 64'(us_valid_o), 64'd0);
      check_eq("rst.src", 64'(grant_src_o), 64'd0);
      check_eq("rst.instr", 64'(instr_o), 64'd0);
      check_eq("rst.data", 64'(full_data2_o), 64'd0);
      tick();
      rst_ni = 1'b1;

      // Slot 0 alone for three cycles, then idle.
      for (int i = 1; i <= 3; i++) begin
         set_in(1'b1, 1'b0, 1'b1, 1'b0, i, 0);
         check_eq("solo.rdy0", 64'(req0_rdy_o), 64'd1);
         check_eq("solo.rdy1", 64'(req1_rdy_o), 64'd0);
         tick();
         check_eq("solo.valid", 64'(us_valid_o), 64'd1);
         check_eq("solo.src", 64'(grant_src_o), 64'd0);
         check_eq("solo.instr", 64'(instr_o), 64'(mk_instr(i)));
      end
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 50, 51);
      check_eq("idle.rdy0", 64'(req0_rdy_o), 64'd0);
      tick();
      check_eq("idle.valid", 64'(us_valid_o), 64'd0);
      check_eq("idle.instr_hold", 64'(instr_o), 64'(mk_instr(3)));

      // Continuous contention: 0,0,0,0,1 repeating.
      for (int i = 0; i < 10; i++)
         arb_cycle("starve", (i % 5) == 4, 100 + i, 200 + i);
`ifdef ALU_ISSUE_ARB_PERF_EN
      check_eq("perf.conflict", 64'(perf_conflict_o), 64'd10);
`endif

      // Two slot-0 wins, a 5-cycle stall, then slot 1 must win on the third.
      arb_cycle("pre_stall0", 1'b0, 300, 400);
      arb_cycle("pre_stall1", 1'b0, 301, 401);
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, 1'b1, 1'b0, 1'b0, 310 + i, 410 + i);
         check_eq("stall.rdy0", 64'(req0_rdy_o), 64'd0);
         check_eq("stall.rdy1", 64'(req1_rdy_o), 64'd0);
         tick();
         check_eq("stall.valid", 64'(us_valid_o), 64'd1);
         check_eq("stall.instr", 64'(instr_o), 64'(mk_instr(301)));
         check_eq("stall.src", 64'(grant_src_o), 64'd0);
      end
      arb_cycle("post_stall0", 1'b0, 320, 420);
      arb_cycle("post_stall1", 1'b0, 321, 421);
      arb_cycle("post_stall2", 1'b1, 322, 422);

      // Build starve=3, flush, then the full four-win run must reappear.
      arb_cycle("pre_flush0", 1'b0, 500, 600);
      arb_cycle("pre_flush1", 1'b0, 501, 601);
      arb_cycle("pre_flush2", 1'b0, 502, 602);
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 503, 603);
      check_eq("flush.rdy0", 64'(req0_rdy_o), 64'd0);
      check_eq("flush.rdy1", 64'(req1_rdy_o), 64'd0);
      tick();
      check_eq("flush.valid", 64'(us_valid_o), 64'd0);
      for (int i = 0; i < 5; i++)
         arb_cycle("post_flush", i == 4, 510 + i, 610 + i);

      // Asynchronous reset while holding a slot-1 instruction.
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 7, 0);
      rst_ni = 1'b0;
      #1;
      check_eq("arst.valid", 64'(us_valid_o), 64'd0);
      check_eq("arst.src", 64'(grant_src_o), 64'd0);
      check_eq("arst.instr", 64'(instr_o), 64'd0);
      tick();
      rst_ni = 1'b1;
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 7, 0);
      check_eq("rel.rdy0", 64'(req0_rdy_o), 64'd1);
      check_eq("rel.valid_pre", 64'(us_valid_o), 64'd0);
      tick();
      check_eq("rel.valid", 64'(us_valid_o), 64'd1);
      check_eq("rel.instr", 64'(instr_o), 64'(mk_instr(7)));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_issue_arb.md
ALU_ISSUE_ARB -- requirements
Module: alu_issue_arb

Interface
REQ-001 Parameter StarveLimit, default 4, number of consecutive lost arbitration cycles for slot 1 before slot 1 is forced to win; legal range 1..15.
REQ-002 Parameter CHERIoTEn, default 1'b1, when 0 forces the cheri_op and is_jal fields of instr_o to zero.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 flush_i  input  1  pipeline flush; kills the held instruction and blocks grants.
REQ-006 req0_valid_i / req1_valid_i  input  1 each  issue slot valid; slot 0 holds the older instruction.
REQ-007 req0_rdy_o / req1_rdy_o  output  1 each  slot accepted this cycle.
REQ-008 req0_instr_i / req1_instr_i  input  ir_dec_t  decoded instruction.
REQ-009 req0_data_i / req1_data_i  input  full_data2_t  forwarded operands.
REQ-010 alupl_rdy_i  input  1  ALU pipeline ready.
REQ-011 us_valid_o  output  1  instruction valid toward the ALU pipeline.
REQ-012 instr_o  output  ir_dec_t  registered instruction.
REQ-013 full_data2_o  output  full_data2_t  registered operands.
REQ-014 grant_src_o  output  1  slot that sourced the held instruction: 0 or 1.

Function
REQ-015 The output register SHALL load when it is empty or alupl_rdy_i=1 (load_en = ~us_valid_o | alupl_rdy_i), giving exactly 1 cycle of latency from accept to us_valid_o.
REQ-016 At most one reqN_rdy_o SHALL be high per cycle; reqN_rdy_o = load_en & ~flush_i & grantN.
REQ-017 Default priority SHALL be slot 0 over slot 1 whenever both slots are valid.
REQ-018 A 4-bit counter starve_q SHALL increment when req1_valid_i=1, load_en=1, flush_i=0, and slot 0 wins; it SHALL saturate at StarveLimit.
REQ-019 When starve_q == StarveLimit and req1_valid_i=1, slot 1 SHALL win over slot 0.
REQ-020 starve_q SHALL clear when slot 1 is granted or when req1_valid_i=0.
REQ-021 When no slot is granted and load_en=1, us_valid_o SHALL go to 0 on the next edge; instr_o and full_data2_o SHALL hold their values.
REQ-022 When us_valid_o=1 and alupl_rdy_i=0, instr_o, full_data2_o and grant_src_o SHALL remain stable.
REQ-023 flush_i=1 SHALL clear us_valid_o and starve_q on the next edge, deassert both rdy outputs in the same cycle, and override every other event in that cycle.
REQ-024 A bubble SHALL NOT be inserted on back-to-back accepts: with alupl_rdy_i held at 1, one instruction per cycle SHALL be sustained.

Reset
REQ-025 On reset, us_valid_o, grant_src_o and starve_q SHALL be 0, and instr_o and full_data2_o SHALL be all-zero.
REQ-026 Reset asserted mid-transfer SHALL drop the held instruction with no partial state remaining.

Configuration
REQ-027 Macro ALU_ISSUE_ARB_PERF_EN SHALL add the output perf_conflict_o (32-bit).
REQ-028 perf_conflict_o SHALL count the cycles with both slots valid and load_en=1; it SHALL wrap at 2^32, reset to 0, and NOT be cleared by flush_i.
REQ-029 Without the macro, the port and counter SHALL be absent and the rest of the behaviour SHALL be identical.

Structure
REQ-030 ir_dec_t and full_data2_t SHALL come from super_pkg, and the arb state struct (valid, src, starve) SHALL be added to super_pkg.
REQ-031 The priority/starvation logic SHALL be a single sub-module, alu_arb_prio, which is purely combinational with starve_q as an input; the registers SHALL stay in the top module.

Verification
REQ-032 Only slot 0 valid for 3 cycles, alupl_rdy_i=1 -> req0_rdy_o=1 for 3 cycles; us_valid_o=1 on cycles 1..3; grant_src_o=0.
REQ-033 Both slots valid continuously, StarveLimit=4, alupl_rdy_i=1 -> grant pattern 0,0,0,0,1 repeating; starve_q returns to 0 after each slot 1 grant.
REQ-034 us_valid_o=1, alupl_rdy_i=0 for 5 cycles with both slots valid -> both rdy outputs 0; instr_o stable; starve_q unchanged.
REQ-035 flush_i pulsed with us_valid_o=1 and starve_q=3 -> next cycle us_valid_o=0, starve_q=0, no accept in the flush cycle.
REQ-036 rst_ni asserted while us_valid_o=1 -> immediately us_valid_o=0 and grant_src_o=0; first accept after release appears 1 cycle later.
REQ-037 ALU_ISSUE_ARB_PERF_EN defined, both slots valid for 10 cycles with alupl_rdy_i=1 -> perf_conflict_o=10.
